amo_shared_unit: RTL and testbench
==================================

// Module: amo_shared_unit
//
// PURPOSE
//   Shared atomic-memory unit for NUM_HARTS cores. It executes RV32A ops
//   (amo_t: LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU) as
//   read-modify-write sequences on one memory port. It keeps one LR/SC
//   reservation per hart and invalidates reservations on conflicting writes.
//   It sits between the per-core load/store units and the shared data-memory
//   arbiter.
//
// PARAMETERS
//   XLEN         32  data/address width
//   NUM_HARTS    2   number of requesting cores (>=1)
//   RESV_GRAN_W  2   low addr bits ignored for reservation match (2 = word)
//
// PORTS
//   clk          in   1               clock
//   rst_n        in   1               async active-low reset
//   req_valid    in   NUM_HARTS       per-hart request valid
//   req_ready    out  NUM_HARTS       per-hart accept (one-hot, 1-cycle)
//   req_op       in   NUM_HARTS*5     per-hart amo_t code
//   req_addr     in   NUM_HARTS*XLEN  per-hart byte address
//   req_data     in   NUM_HARTS*XLEN  per-hart rs2 operand
//   rsp_valid    out  NUM_HARTS       one-hot response strobe (1 cycle)
//   rsp_data     out  XLEN            result: old value, or SC 0/1
//   rsp_err      out  1               misaligned or illegal op (with rsp_valid)
//   mem_req      out  1               memory access request
//   mem_we       out  1               1 = write, 0 = read
//   mem_addr     out  XLEN            word address (addr[1:0] forced 0)
//   mem_wdata    out  XLEN            write data
//   mem_ack      in   1               access complete (read data valid)
//   mem_rdata    in   XLEN            read data
//   snoop_valid  in   1               plain store by any hart is committing
//   snoop_addr   in   XLEN            address of that store
//
// BEHAVIOUR
// - Reset (async): FSM=IDLE, rr pointer=0, all reservations invalid; every
//   output 0.
// - FSM: IDLE -> RD -> WR -> RSP -> IDLE. RD/WR are skipped per op:
//   - LR: RD, RSP.
//   - SC: WR, RSP on reservation hit; RSP only on miss.
//   - Other AMO: RD, WR, RSP.
//   - Error: RSP only.
// - IDLE: round-robin grant among req_valid, starting at the rr pointer.
//   - req_ready[g] pulses; op/addr/data are latched; rr pointer = g+1 mod N.
//   - No grant while not in IDLE. Requesters hold inputs until ready.
// - RD/WR: mem_req=1 with addr and wdata held stable until mem_ack. Leave
//   the state on mem_req & mem_ack. Ack in the first cycle is legal.
// - AMO compute uses registered mem_rdata:
//   - MIN/MAX signed, MINU/MAXU unsigned compare.
//   - ADD wraps mod 2^XLEN.
//   - SWAP writes rs2.
// - rsp_data: LR and AMO return the old memory value. SC returns 0 on
//   success, 1 on failure.
// - Errors: addr[1:0]!=0 or an op not in amo_t -> rsp_err=1, rsp_data=0,
//   no memory access, reservations unchanged.
// - Reservations: resv_v[h], resv_a[h] = addr[XLEN-1:RESV_GRAN_W].
//   - LR sets its hart's entry on RD ack.
//   - SC hit = resv_v[h] & tag match. Any SC clears its own hart's entry.
//   - Every WR issued here clears all harts' entries with matching tag.
//   - snoop_valid clears all entries with matching tag.
//   - Snoop and LR set in the same cycle, same tag: entry ends invalid.
// - Latency from grant, with zero-wait memory (ack in first cycle):
//   - LR = 3 cycles.
//   - AMO = 4 cycles.
//   - SC hit = 3 cycles, SC miss = 2 cycles.
//   - Error = 2 cycles.
// - Reset mid-operation aborts immediately: mem_req drops, no response.
//
// TESTING
// - LR/SC pair: H0 LR 0x100 (mem=0x5) -> rsp 0x5; H0 SC 0x100 data 0x9 ->
//   rsp 0, mem[0x100]=0x9.
// - Steal: H0 LR 0x100; H1 SC 0x100 -> rsp 1, no write. H1 AMOADD 0x100 +1;
//   H0 SC -> rsp 1.
// - Snoop clear: H0 LR 0x200; snoop 0x202 -> H0 SC 0x200 rsp 1. Snoop 0x204
//   (other word) -> SC rsp 0.
// - Arithmetic: mem=0xFFFFFFFF, AMOMIN rs2=1 -> rsp 0xFFFFFFFF, mem unchanged.
//   AMOMINU rs2=1 -> mem=1. AMOADD rs2=1 on 0xFFFFFFFF -> mem=0.
// - Fairness: both harts assert continuously; grants alternate H0,H1,H0,...;
//   no grant while busy.
// - Errors/reset: AMOSWAP 0x101 -> rsp_err=1, mem_req never set. rst_n low
//   during WR wait -> mem_req=0 same cycle, reservations invalid.

Source files
------------

// File: rtl/amo_shared_unit.sv
// Shared RV32A atomic unit: arbitrates per-hart AMO/LR/SC requests onto one
// memory port as read-modify-write sequences and tracks per-hart reservations.
module amo_shared_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_HARTS   = 2,
  parameter int unsigned RESV_GRAN_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      req_valid,
  output logic [NUM_HARTS-1:0]      req_ready,
  input  logic [NUM_HARTS*5-1:0]    req_op,
  input  logic [NUM_HARTS*XLEN-1:0] req_addr,
  input  logic [NUM_HARTS*XLEN-1:0] req_data,
  output logic [NUM_HARTS-1:0]      rsp_valid,
  output logic [XLEN-1:0]           rsp_data,
  output logic                      rsp_err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic                      mem_ack,
  input  logic [XLEN-1:0]           mem_rdata,
  input  logic                      snoop_valid,
  input  logic [XLEN-1:0]           snoop_addr
);

  localparam int unsigned HW  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam int unsigned TW  = XLEN - RESV_GRAN_W;
  localparam int unsigned OPW = 5;

  typedef enum logic [OPW-1:0] {
    AMO_ADD  = 5'h00, AMO_SWAP = 5'h01, AMO_LR   = 5'h02, AMO_SC   = 5'h03,
    AMO_XOR  = 5'h04, AMO_OR   = 5'h08, AMO_AND  = 5'h0C, AMO_MIN  = 5'h10,
    AMO_MAX  = 5'h14, AMO_MINU = 5'h18, AMO_MAXU = 5'h1C
  } amo_t;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  function automatic logic f_legal(input logic [OPW-1:0] op);
    case (op)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: f_legal = 1'b1;
      default:                              f_legal = 1'b0;
    endcase
  endfunction

  state_t                r_state, w_state_nxt;
  logic [HW-1:0]         r_rr, w_rr_nxt;
  logic [HW-1:0]         r_hart, w_hart_nxt;
  logic [OPW-1:0]        r_op, w_op_nxt;
  logic [TW-1:0]         r_tag, w_tag_nxt;
  logic [XLEN-1:0]       r_data, w_data_nxt;
  logic [XLEN-1:0]       r_rdata, w_rdata_nxt;
  logic                  r_sc_ok, w_sc_ok_nxt;
  logic                  r_err, w_err_nxt;
  logic [NUM_HARTS-1:0]  r_req_ready, w_ready_nxt;
  logic [NUM_HARTS-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [XLEN-1:0]       r_rsp_data, w_rsp_data_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [XLEN-1:0]       r_mem_addr, w_mem_addr_nxt;
  logic                  w_sc_clr;

  logic [NUM_HARTS-1:0]  r_resv_v;
  logic [TW-1:0]         r_resv_a [NUM_HARTS];

  logic [HW-1:0]         w_gnt;
  logic                  w_gnt_vld;
  logic [OPW-1:0]        w_op;
  logic [XLEN-1:0]       w_addr;
  logic [XLEN-1:0]       w_data;
  logic [TW-1:0]         w_tag;
  logic [TW-1:0]         w_snoop_tag;
  logic                  w_sc_hit;
  logic                  w_err;
  logic [XLEN-1:0]       w_alu;
  logic                  w_wr_done;
  logic                  w_lr_set;
  logic                  w_unused_snoop_lo;

  // Round-robin pick, first valid hart at or after the pointer
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (!w_gnt_vld && req_valid[(32'(r_rr) + i) % NUM_HARTS]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = HW'((32'(r_rr) + i) % NUM_HARTS);
      end
    end
  end

  assign w_op        = req_op[w_gnt*OPW +: OPW];
  assign w_addr      = req_addr[w_gnt*XLEN +: XLEN];
  assign w_data      = req_data[w_gnt*XLEN +: XLEN];
  assign w_tag       = w_addr[XLEN-1:RESV_GRAN_W];
  assign w_snoop_tag = snoop_addr[XLEN-1:RESV_GRAN_W];
  assign w_err       = (|w_addr[1:0]) || !f_legal(w_op);
  // A snoop landing on the same edge as the SC decision wins over the reservation
  assign w_sc_hit    = r_resv_v[w_gnt] && (r_resv_a[w_gnt] == w_tag) &&
                       !(snoop_valid && (w_snoop_tag == w_tag));
  assign w_unused_snoop_lo = &{1'b0, snoop_addr[RESV_GRAN_W-1:0]};

  // Write-data ALU works from the registered read value
  always_comb begin
    w_alu = r_data;
    case (r_op)
      AMO_ADD:  w_alu = r_rdata + r_data;
      AMO_XOR:  w_alu = r_rdata ^ r_data;
      AMO_AND:  w_alu = r_rdata & r_data;
      AMO_OR:   w_alu = r_rdata | r_data;
      AMO_MIN:  w_alu = ($signed(r_data) < $signed(r_rdata)) ? r_data : r_rdata;
      AMO_MAX:  w_alu = ($signed(r_data) > $signed(r_rdata)) ? r_data : r_rdata;
      AMO_MINU: w_alu = (r_data < r_rdata) ? r_data : r_rdata;
      AMO_MAXU: w_alu = (r_data > r_rdata) ? r_data : r_rdata;
      default:  w_alu = r_data;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr;
    w_hart_nxt      = r_hart;
    w_op_nxt        = r_op;
    w_tag_nxt       = r_tag;
    w_data_nxt      = r_data;
    w_rdata_nxt     = r_rdata;
    w_sc_ok_nxt     = r_sc_ok;
    w_err_nxt       = r_err;
    w_ready_nxt     = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = '0;
    w_rsp_err_nxt   = 1'b0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_sc_clr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_ready_nxt[w_gnt] = 1'b1;
          w_rr_nxt       = (32'(w_gnt) == NUM_HARTS - 1) ? '0 : w_gnt + HW'(1);
          w_hart_nxt     = w_gnt;
          w_op_nxt       = w_op;
          w_tag_nxt      = w_tag;
          w_data_nxt     = w_data;
          w_err_nxt      = w_err;
          w_sc_ok_nxt    = w_sc_hit;
          w_mem_addr_nxt = {w_addr[XLEN-1:2], 2'b00};
          if (w_err) begin
            w_state_nxt = S_RSP;
          end else if (w_op == AMO_SC) begin
            w_sc_clr = 1'b1;
            if (w_sc_hit) begin
              w_state_nxt   = S_WR;
              w_mem_req_nxt = 1'b1;
              w_mem_we_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RSP;
            end
          end else begin
            w_state_nxt   = S_RD;
            w_mem_req_nxt = 1'b1;
            w_mem_we_nxt  = 1'b0;
          end
        end
      end
      S_RD: begin
        if (r_mem_req && mem_ack) begin
          w_rdata_nxt = mem_rdata;
          if (r_op == AMO_LR) begin
            w_state_nxt   = S_RSP;
            w_mem_req_nxt = 1'b0;
          end else begin
            w_state_nxt  = S_WR;
            w_mem_we_nxt = 1'b1;
          end
        end
      end
      S_WR: begin
        if (r_mem_req && mem_ack) begin
          w_state_nxt   = S_RSP;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
        end
      end
      S_RSP: begin
        w_state_nxt             = S_IDLE;
        w_rsp_valid_nxt[r_hart] = 1'b1;
        w_rsp_err_nxt           = r_err;
        if (r_err)                 w_rsp_data_nxt = '0;
        else if (r_op == AMO_SC)   w_rsp_data_nxt = {{(XLEN-1){1'b0}}, ~r_sc_ok};
        else                       w_rsp_data_nxt = r_rdata;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_hart      <= '0;
      r_op        <= '0;
      r_tag       <= '0;
      r_data      <= '0;
      r_rdata     <= '0;
      r_sc_ok     <= 1'b0;
      r_err       <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr        <= w_rr_nxt;
      r_hart      <= w_hart_nxt;
      r_op        <= w_op_nxt;
      r_tag       <= w_tag_nxt;
      r_data      <= w_data_nxt;
      r_rdata     <= w_rdata_nxt;
      r_sc_ok     <= w_sc_ok_nxt;
      r_err       <= w_err_nxt;
      r_req_ready <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
    end
  end

  assign w_wr_done = (r_state == S_WR) && r_mem_req && mem_ack;
  assign w_lr_set  = (r_state == S_RD) && r_mem_req && mem_ack && (r_op == AMO_LR);

  // Reservation table: LR sets, SC/local writes/snoops clear; snoop beats a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resv_v <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) r_resv_a[h] <= '0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (w_lr_set && (r_hart == HW'(h))) begin
          r_resv_v[h] <= !(snoop_valid && (w_snoop_tag == r_tag));
          r_resv_a[h] <= r_tag;
        end else if ((snoop_valid && (r_resv_a[h] == w_snoop_tag)) ||
                     (w_wr_done && (r_resv_a[h] == r_tag)) ||
                     (w_sc_clr && (w_gnt == HW'(h)))) begin
          r_resv_v[h] <= 1'b0;
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = (r_state == S_WR) ? w_alu : '0;

endmodule

// File: tb/tb_amo_shared_unit.sv
// Directed bench for amo_shared_unit: vector table of single ops against a
// behavioural memory, plus fairness and reset-abort sequences.
module tb_amo_shared_unit;

  localparam logic [4:0] OP_ADD  = 5'h00, OP_SWAP = 5'h01, OP_LR   = 5'h02,
                         OP_SC   = 5'h03, OP_XOR  = 5'h04, OP_OR   = 5'h08,
                         OP_AND  = 5'h0C, OP_MIN  = 5'h10, OP_MAX  = 5'h14,
                         OP_MINU = 5'h18, OP_MAXU = 5'h1C, OP_BAD  = 5'h1F;

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [9:0]  req_op;
  logic [63:0] req_addr, req_data;
  logic [31:0] rsp_data, mem_addr, mem_wdata, mem_rdata, snoop_addr;
  logic        rsp_err, mem_req, mem_we, mem_ack, snoop_valid;

  logic [31:0] mem [256];
  int          ack_delay;
  int          wait_cnt;
  int          n_checks;
  int          n_fail;

  amo_shared_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after ack_delay extra cycles of mem_req, combinational read
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Address/data/we must hold while an access waits for ack
  logic        p_wait, p_we;
  logic [31:0] p_addr, p_wdata;
  initial p_wait = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_wait = 1'b0;
    end else begin
      if (p_wait && mem_req) begin
        chk("mem stable addr", mem_addr, p_addr);
        chk("mem stable wdata", mem_wdata, p_wdata);
        chk("mem stable we", 32'(mem_we), 32'(p_we));
      end
      p_wait  = mem_req && !mem_ack;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_we    = mem_we;
    end
  end

  // Issue one request; lat counts from the IDLE grant cycle (one before ready)
  task automatic run_op(input int h, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata,
                        output logic err, output int lat, output int nreq);
    bit got;
    req_op[h*5 +: 5]    = op;
    req_addr[h*32 +: 32] = addr;
    req_data[h*32 +: 32] = data;
    req_valid[h]        = 1'b1;
    rdata = '0; err = 1'b0; lat = 0; nreq = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[h]) got = 1'b1;
    end
    req_valid[h] = 1'b0;
    if (!got) begin
      fail_to("grant");
      return;
    end
    if (mem_req) nreq++;
    got = 1'b0;
    for (int c = 1; c < 100 && !got; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (rsp_valid[h]) begin
        got = 1'b1; rdata = rsp_data; err = rsp_err; lat = c + 1;
      end
    end
    if (!got) fail_to("response");
  endtask

  typedef struct {
    int          hart;
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    bit          snoop;
    logic [31:0] saddr;
    int          waitc;
    logic [31:0] exp_rsp;
    bit          exp_err;
    int          exp_lat;
    logic [31:0] exp_mem;
  } vec_t;

  function automatic vec_t mk(int h, logic [4:0] op, logic [31:0] a, logic [31:0] d,
                              bit sn, logic [31:0] sa, int w, logic [31:0] er,
                              bit ee, int el, logic [31:0] em);
    vec_t v;
    v.hart = h; v.op = op; v.addr = a; v.data = d; v.snoop = sn; v.saddr = sa;
    v.waitc = w; v.exp_rsp = er; v.exp_err = ee; v.exp_lat = el; v.exp_mem = em;
    return v;
  endfunction

  vec_t        vecs[$];
  vec_t        v;
  logic [31:0] rd;
  logic        er;
  int          lat, nreq, ng;
  int          order[4];
  bit          busy, got;

  initial begin
    rst_n = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_data = '0;
    snoop_valid = 1'b0; snoop_addr = '0; ack_delay = 0; n_checks = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] <= '0;
    mem[8'h40] <= 32'h0000_0005;
    mem[8'h80] <= 32'h0000_0077;
    mem[8'hC0] <= 32'hFFFF_FFFF;
    mem[8'hC1] <= 32'h0000_0010;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_data", rsp_data, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'h0);
    chk("reset mem_req", 32'(mem_req), 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //            hart op       addr          data          snp saddr   wait rsp           err lat mem
    vecs.push_back(mk(0, OP_LR,   32'h100, 32'h0,          0, 32'h0,   0, 32'h5,          0, 3, 32'h5));
    vecs.push_back(mk(0, OP_SC,   32'h100, 32'h9,          0, 32'h0,   0, 32'h0,          0, 3, 32'h9));
    vecs.push_back(mk(0, OP_LR,   32'h100, 32'h0,          0, 32'h0,   0, 32'h9,          0, 3, 32'h9));
    vecs.push_back(mk(1, OP_SC,   32'h100, 32'h55,         0, 32'h0,   0, 32'h1,          0, 2, 32'h9));
    vecs.push_back(mk(1, OP_ADD,  32'h100, 32'h1,          0, 32'h0,   0, 32'h9,          0, 4, 32'hA));
    vecs.push_back(mk(0, OP_SC,   32'h100, 32'h66,         0, 32'h0,   0, 32'h1,          0, 2, 32'hA));
    vecs.push_back(mk(0, OP_LR,   32'h200, 32'h0,          0, 32'h0,   0, 32'h77,         0, 3, 32'h77));
    vecs.push_back(mk(0, OP_SC,   32'h200, 32'h1,          1, 32'h202, 0, 32'h1,          0, 2, 32'h77));
    vecs.push_back(mk(0, OP_LR,   32'h200, 32'h0,          0, 32'h0,   0, 32'h77,         0, 3, 32'h77));
    vecs.push_back(mk(0, OP_SC,   32'h200, 32'h2,          1, 32'h204, 0, 32'h0,          0, 3, 32'h2));
    vecs.push_back(mk(1, OP_MIN,  32'h300, 32'h1,          0, 32'h0,   0, 32'hFFFF_FFFF,  0, 4, 32'hFFFF_FFFF));
    vecs.push_back(mk(1, OP_MINU, 32'h300, 32'h1,          0, 32'h0,   0, 32'hFFFF_FFFF,  0, 4, 32'h1));
    vecs.push_back(mk(0, OP_SWAP, 32'h300, 32'hFFFF_FFFF,  0, 32'h0,   0, 32'h1,          0, 4, 32'hFFFF_FFFF));
    vecs.push_back(mk(0, OP_ADD,  32'h300, 32'h1,          0, 32'h0,   0, 32'hFFFF_FFFF,  0, 4, 32'h0));
    vecs.push_back(mk(1, OP_MAX,  32'h304, 32'hFFFF_FFF0,  0, 32'h0,   0, 32'h10,         0, 4, 32'h10));
    vecs.push_back(mk(1, OP_MAXU, 32'h304, 32'hFFFF_FFF0,  0, 32'h0,   0, 32'h10,         0, 4, 32'hFFFF_FFF0));
    vecs.push_back(mk(0, OP_XOR,  32'h304, 32'h0F0F_0F0F,  0, 32'h0,   0, 32'hFFFF_FFF0,  0, 4, 32'hF0F0_F0FF));
    vecs.push_back(mk(0, OP_AND,  32'h304, 32'h00FF_00FF,  0, 32'h0,   0, 32'hF0F0_F0FF,  0, 4, 32'h00F0_00FF));
    vecs.push_back(mk(1, OP_OR,   32'h304, 32'h0F00_0000,  0, 32'h0,   0, 32'h00F0_00FF,  0, 4, 32'h0FF0_00FF));
    vecs.push_back(mk(0, OP_ADD,  32'h304, 32'h1,          0, 32'h0,   2, 32'h0FF0_00FF,  0, 8, 32'h0FF0_0100));
    vecs.push_back(mk(0, OP_SWAP, 32'h101, 32'h1234,       0, 32'h0,   0, 32'h0,          1, 2, 32'hA));
    vecs.push_back(mk(1, OP_BAD,  32'h100, 32'h1234,       0, 32'h0,   0, 32'h0,          1, 2, 32'hA));
    vecs.push_back(mk(1, OP_SC,   32'h304, 32'h5,          0, 32'h0,   0, 32'h1,          0, 2, 32'h0FF0_0100));

    foreach (vecs[i]) begin
      v = vecs[i];
      ack_delay = v.waitc;
      if (v.snoop) begin
        @(negedge clk);
        snoop_valid = 1'b1; snoop_addr = v.saddr;
        @(negedge clk);
        snoop_valid = 1'b0;
      end
      run_op(v.hart, v.op, v.addr, v.data, rd, er, lat, nreq);
      chk($sformatf("v%0d rsp_data", i), rd, v.exp_rsp);
      chk($sformatf("v%0d rsp_err", i), 32'(er), 32'(v.exp_err));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d mem", i), mem[v.addr[9:2]], v.exp_mem);
      if (v.exp_err) chk($sformatf("v%0d err mem_req cycles", i), 32'(nreq), 32'h0);
    end
    ack_delay = 0;

    // Fairness: both harts request continuously; last grant was H1 so H0 leads
    req_op = {OP_LR, OP_LR};
    req_addr = {32'h200, 32'h100};
    req_valid = 2'b11;
    ng = 0; busy = 1'b0;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) busy = 1'b0;
      if (req_ready != 2'b00) begin
        chk("fair no grant while busy", 32'(busy), 32'h0);
        chk("fair onehot", 32'($countones(req_ready)), 32'h1);
        order[ng] = req_ready[1] ? 1 : 0;
        chk($sformatf("fair grant %0d", ng), 32'(order[ng]), 32'(ng % 2));
        ng++;
        busy = 1'b1;
      end
    end
    req_valid = 2'b00;
    if (ng < 4) fail_to("fairness grants");
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) got = 1'b1;
    end
    if (!got) fail_to("fairness last response");

    // Reset while a write waits for ack: abort, no write, reservations lost
    run_op(0, OP_LR, 32'h100, 32'h0, rd, er, lat, nreq);
    chk("pre-reset LR", rd, 32'hA);
    ack_delay = 5;
    req_op[9:5] = OP_ADD; req_addr[63:32] = 32'h304; req_data[63:32] = 32'h1;
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
    end
    req_valid[1] = 1'b0;
    if (!got) fail_to("reset-test grant");
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) got = 1'b1;
    end
    if (!got) fail_to("reset-test write phase");
    rst_n = 1'b0;
    #1;
    chk("abort mem_req", 32'(mem_req), 32'h0);
    chk("abort mem_we", 32'(mem_we), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("abort no rsp", 32'(rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    chk("abort no rsp after release", 32'(rsp_valid), 32'h0);
    chk("abort mem untouched", mem[8'hC1], 32'h0FF0_0100);
    run_op(0, OP_SC, 32'h100, 32'h33, rd, er, lat, nreq);
    chk("post-reset SC fails", rd, 32'h1);
    chk("post-reset SC no write", mem[8'h40], 32'hA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
